// File: rtl/tpu_pkg.sv
// Shared types and constants for the TPU writeback DMA (AXI4 write master).
package tpu_pkg;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

    // FSM state encoding, kept as plain constants for legacy tools.
    typedef logic [2:0] wb_state_t;
    localparam wb_state_t ST_IDLE = 3'd0;
    localparam wb_state_t ST_RD   = 3'd1;
    localparam wb_state_t ST_CAP  = 3'd2;
    localparam wb_state_t ST_AW   = 3'd3;
    localparam wb_state_t ST_W    = 3'd4;
    localparam wb_state_t ST_B    = 3'd5;
    localparam wb_state_t ST_DONE = 3'd6;

    function automatic int bytes_per_word(input int data_width);
        return data_width / 8;
    endfunction

    function automatic int row_bytes(input int words, input int data_width);
        return words * (data_width / 8);
    endfunction

endpackage

// File: rtl/tpu_wb_row_serializer.sv
// Holds one result row and presents it one word per W beat, index 0 first.
module tpu_wb_row_serializer #(
    parameter int W  = 16,
    parameter int DW = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic [W*DW-1:0] row_in,
    input  logic            advance,
    output logic [DW-1:0]   word,
    output logic            last
);
    localparam int CW = (W > 1) ? $clog2(W) : 1;

    logic [W*DW-1:0] row_q;
    logic [CW-1:0]   beat;

    // Parallel load restarts the beat counter; each accepted beat steps it.
    always_ff @(posedge clk) begin
        if (rst) begin
            row_q <= '0;
            beat  <= '0;
        end else if (load) begin
            row_q <= row_in;
            beat  <= '0;
        end else if (advance && !last) begin
            beat <= beat + CW'(1);
        end
    end

    assign word = row_q[beat*DW +: DW];
    assign last = (beat == CW'(W - 1));

endmodule

// File: rtl/tpu_writeback_dma.sv
// Writeback DMA: reads result rows from the core buffer and writes each row
// as one AXI4 INCR burst. Optional perf counters: TPU_WB_PERF_CNT_EN.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high; valid never drops and its payload never changes before that.
module tpu_writeback_dma
    import tpu_pkg::*;
#(
    parameter int SYSTOLIC_ARRAY_WIDTH = 16,
    parameter int DATA_WIDTH_ACCUM     = 32,
    parameter int ADDR_WIDTH           = 10,
    parameter int AXI_ADDR_WIDTH       = 32
) (
    input  logic                                           clk,
    input  logic                                           rst,
    input  logic                                           start_pulse,
    input  logic [AXI_ADDR_WIDTH-1:0]                      dest_addr,
    input  logic [ADDR_WIDTH-1:0]                          src_addr,
    input  logic [15:0]                                    length,
    output logic                                           done_irq,
    output logic                                           busy,
    output logic                                           err,
    output logic [ADDR_WIDTH-1:0]                          rd_addr,
    output logic                                           rd_en,
    input  logic [SYSTOLIC_ARRAY_WIDTH*DATA_WIDTH_ACCUM-1:0] rd_data,
    output logic [AXI_ADDR_WIDTH-1:0]                      m_axi_awaddr,
    output logic [7:0]                                     m_axi_awlen,
    output logic [2:0]                                     m_axi_awsize,
    output logic [1:0]                                     m_axi_awburst,
    output logic                                           m_axi_awvalid,
    input  logic                                           m_axi_awready,
    output logic [DATA_WIDTH_ACCUM-1:0]                    m_axi_wdata,
    output logic [DATA_WIDTH_ACCUM/8-1:0]                  m_axi_wstrb,
    output logic                                           m_axi_wlast,
    output logic                                           m_axi_wvalid,
    input  logic                                           m_axi_wready,
    input  logic [1:0]                                     m_axi_bresp,
    input  logic                                           m_axi_bvalid,
    output logic                                           m_axi_bready
`ifdef TPU_WB_PERF_CNT_EN
   ,output logic [31:0]                                    perf_busy_cycles,
    output logic [31:0]                                    perf_stall_cycles
`endif
);
    localparam int W   = SYSTOLIC_ARRAY_WIDTH;
    localparam int BPW = bytes_per_word(DATA_WIDTH_ACCUM);
    localparam int RB  = row_bytes(W, DATA_WIDTH_ACCUM);

    localparam logic [AXI_ADDR_WIDTH-1:0] LOW_MASK = AXI_ADDR_WIDTH'(RB - 1);
    localparam logic [AXI_ADDR_WIDTH-1:0] ROW_STEP = AXI_ADDR_WIDTH'(RB);
    localparam logic [2:0]                AW_SIZE  = 3'($clog2(BPW));

    wb_state_t                 state;
    logic [AXI_ADDR_WIDTH-1:0] aw_addr_q;
    logic [15:0]               rows_left;
    logic                      err_q;
    logic                      start_accept;
    logic                      misaligned;
    logic                      w_last;

    assign start_accept = (state == ST_IDLE) && start_pulse;
    // A row-misaligned base could let a burst straddle a 4 KB page.
    assign misaligned   = |(dest_addr & LOW_MASK);

    // Command sequencing: one row read, one burst, one response at a time.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            rd_addr   <= '0;
            aw_addr_q <= '0;
            rows_left <= '0;
            err_q     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start_pulse) begin
                        err_q     <= misaligned;
                        rd_addr   <= src_addr;
                        aw_addr_q <= dest_addr & ~LOW_MASK;
                        rows_left <= length;
                        state     <= (length == 16'd0) ? ST_DONE : ST_RD;
                    end
                end
                ST_RD:  state <= ST_CAP;
                ST_CAP: state <= ST_AW;
                ST_AW: begin
                    if (m_axi_awready) state <= ST_W;
                end
                ST_W: begin
                    if (m_axi_wready && w_last) state <= ST_B;
                end
                ST_B: begin
                    if (m_axi_bvalid) begin
                        if (m_axi_bresp != AXI_RESP_OKAY) err_q <= 1'b1;
                        rows_left <= rows_left - 16'd1;
                        if (rows_left == 16'd1) begin
                            state <= ST_DONE;
                        end else begin
                            rd_addr   <= rd_addr + ADDR_WIDTH'(1);
                            aw_addr_q <= aw_addr_q + ROW_STEP;
                            state     <= ST_RD;
                        end
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    tpu_wb_row_serializer #(
        .W  (W),
        .DW (DATA_WIDTH_ACCUM)
    ) u_ser (
        .clk     (clk),
        .rst     (rst),
        .load    (state == ST_CAP),
        .row_in  (rd_data),
        .advance ((state == ST_W) && m_axi_wready),
        .word    (m_axi_wdata),
        .last    (w_last)
    );

    assign done_irq      = (state == ST_DONE);
    assign busy          = (state != ST_IDLE);
    assign err           = err_q;
    assign rd_en         = (state == ST_RD);
    assign m_axi_awaddr  = aw_addr_q;
    assign m_axi_awlen   = 8'(W - 1);
    assign m_axi_awsize  = AW_SIZE;
    assign m_axi_awburst = AXI_BURST_INCR;
    assign m_axi_awvalid = (state == ST_AW);
    assign m_axi_wstrb   = '1;
    assign m_axi_wlast   = (state == ST_W) && w_last;
    assign m_axi_wvalid  = (state == ST_W);
    assign m_axi_bready  = (state == ST_B);

`ifdef TPU_WB_PERF_CNT_EN
    logic stall;
    assign stall = (m_axi_awvalid && !m_axi_awready) || (m_axi_wvalid && !m_axi_wready);

    // Saturating activity counters, restarted by each accepted command.
    always_ff @(posedge clk) begin
        if (rst || start_accept) begin
            perf_busy_cycles  <= '0;
            perf_stall_cycles <= '0;
        end else begin
            if (busy && !(&perf_busy_cycles))
                perf_busy_cycles <= perf_busy_cycles + 32'd1;
            if (stall && !(&perf_stall_cycles))
                perf_stall_cycles <= perf_stall_cycles + 32'd1;
        end
    end
`endif

endmodule
